fp32_operand_join: RTL



---
 rtl/fp32_operand_join.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fp32_operand_join.sv
// Purpose : pairs two independent FP32 operand streams in arrival order for the FP32 adder.
// Latency : 2 edges from simultaneous accept on an idle block to out_valid.
// Backpressure: a_ready/b_ready drop on a full FIFO (registered levels only); out_ready stalls the output register.
//
// Ports:
//   clk, rst (sync, active-high), flush (sync clear of FIFOs and output valid)
//   a/a_valid/a_ready, b/b_valid/b_ready : operand input streams
//   out_a/out_b, out_a_cls/out_b_cls, out_valid/out_ready : registered paired output
//   a_level/b_level : FIFO occupancy
// Build option: define FP_JOIN_CLASSIFY_EN to build the IEEE-754 class decoder and tag registers;
// otherwise the tag outputs are tied to 3'd0.

module op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int PW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage carries no reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && !clr && push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module fp32_operand_join #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [W-1:0]             a,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [W-1:0]             b,
    input  logic                     b_valid,
    output logic                     b_ready,
    output logic [W-1:0]             out_a,
    output logic [W-1:0]             out_b,
    output logic [2:0]               out_a_cls,
    output logic [2:0]               out_b_cls,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   a_level,
    output logic [$clog2(DEPTH):0]   b_level
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [W-1:0] a_head;
    logic [W-1:0] b_head;
    logic         a_push;
    logic         b_push;
    logic         load;

    // Readiness is purely a function of registered levels: no path from out_ready.
    assign a_ready = (a_level != LW'(DEPTH));
    assign b_ready = (b_level != LW'(DEPTH));
    assign a_push  = a_valid && a_ready;
    assign b_push  = b_valid && b_ready;

    // Flush wins over load; the FIFOs ignore push/pop during clr on their own.
    assign load = (a_level != '0) && (b_level != '0) && (!out_valid || out_ready) && !flush;

    op_fifo #(.DEPTH(DEPTH), .W(W)) u_a_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (a_push),
        .push_dat (a),
        .pop      (load),
        .head_dat (a_head),
        .level    (a_level)
    );

    op_fifo #(.DEPTH(DEPTH), .W(W)) u_b_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (b_push),
        .push_dat (b),
        .pop      (load),
        .head_dat (b_head),
        .level    (b_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_a     <= a_head;
            out_b     <= b_head;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FP_JOIN_CLASSIFY_EN
    // Tag encoding: 0 normal, 1 zero, 2 subnormal, 3 inf, 4 qNaN, 5 sNaN. Sign ignored.
    function automatic logic [2:0] fp_class(input logic [W-1:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        e = v[30:23];
        m = v[22:0];
        if (e == 8'd0)        fp_class = (m == '0) ? 3'd1 : 3'd2;
        else if (e == 8'hFF)  fp_class = (m == '0) ? 3'd3 : (m[22] ? 3'd4 : 3'd5);
        else                  fp_class = 3'd0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            out_a_cls <= 3'd0;
            out_b_cls <= 3'd0;
        end else if (load) begin
            out_a_cls <= fp_class(a_head);
            out_b_cls <= fp_class(b_head);
        end
    end
`else
    assign out_a_cls = 3'd0;
    assign out_b_cls = 3'd0;
`endif
endmodule
